// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues one word fetch at
// a time over a request/response instruction-memory port, and holds the
// returned instruction (with pre-split fields) until decode consumes it.
// Branch/jump redirects retarget the PC and squash any in-flight response.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory port
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decode port
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  // branch/jump resolution
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential PC step; 32-bit arithmetic wraps 0xFFFF_FFFC -> 0x0000_0000.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        discard_q;
  logic        discard_d;
  logic        capture;
  logic        accept;
  logic [31:0] redirect_target;

  assign accept          = (state_q == S_FETCH) && imem_ready;
  assign redirect_target = word_align(redirect_pc);

  // State register; reset aborts any state, including an outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response outside WAIT is a protocol violation and ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          // A squashed or redirected response goes straight back to fetching.
          if (discard_q || redirect_valid) state_d = S_FETCH;
          else                              state_d = S_HOLD;
        end
      end
      S_HOLD:  if (decode_ready || redirect_valid) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: request and valid come straight from the state register.
  always_comb begin
    imem_req    = (state_q == S_FETCH);
    instr_valid = (state_q == S_HOLD);
  end

  // Next PC, discard flag and capture strobe for the datapath registers.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    capture   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          // The request leaving this cycle is for the old path; drop its reply.
          if (accept) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          if (redirect_valid) begin
            // Reply arrives with the redirect: it is stale, drop it now.
            pc_d = redirect_target;
          end else if (!discard_q) begin
            capture = 1'b1;
            pc_d    = pc_inc(pc_q);
          end
        end else if (redirect_valid) begin
          pc_d      = redirect_target;
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) pc_d = redirect_target;
      end
      default: begin
        // Redirects in IDLE are ignored.
        pc_d = pc_q;
      end
    endcase
  end

  // Datapath registers: fetch PC, held instruction and its address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC_A;
      instr_q   <= 32'h0000_0000;
      pc_out_q  <= RESET_PC_A;
      discard_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      if (capture) begin
        instr_q  <= imem_rdata;
        pc_out_q <= pc_q;
      end
    end
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign pc_out    = pc_out_q;
  assign pc_plus4  = pc_inc(pc_out_q);

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];
  assign imm16  = instr_q[15:0];

endmodule
